// File: rtl/uart_tx_drain.sv
// UART transmitter draining a byte FIFO: pop, load, then start/data/stop.
// Every output is registered from next-state values, so it lines up with state_q.
module uart_tx_drain #(
    parameter int CLK_DIV   = 139,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DATA_BITS-1:0] fifo_data_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_o,
    input  logic                 cts_n_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty_i && !cts_n_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = START;
                shift_d = fifo_data_i;
                baud_d  = '0;
                bit_d   = '0;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output registers are loaded from the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        rd_d   = (state_d == POP);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST)
                 && (bit_d == STOP_LAST);
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    assign tx_o         = tx_q;
    assign fifo_rd_o    = rd_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: a small FIFO model feeds each instance.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_uart_tx_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cts_n;
    logic       cts1_n;
    logic [7:0] fdata0 = '0;
    logic [7:0] fdata1 = '0;
    logic       fempty0, fempty1;
    logic       rd0, tx0, busy0, done0;
    logic       rd1, tx1, busy1, done1;

    logic [7:0] mem [0:15];
    int push0 = 0;
    int pop0  = 0;
    int rdp0  = 0;
    int push1 = 0;
    int pop1  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    assign fempty0 = (push0 == pop0);
    assign fempty1 = (push1 == pop1);

    always @(posedge clk) begin
        if (rd0) begin
            rdp0 <= rdp0 + 1;
            if (push0 != pop0) begin
                fdata0 <= mem[pop0[3:0]];
                pop0   <= pop0 + 1;
            end
        end
        if (rd1 && push1 != pop1) begin
            fdata1 <= 8'h55;
            pop1   <= pop1 + 1;
        end
    end

    uart_tx_drain #(
        .CLK_DIV  (4),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) u_dut0 (
        .clk_i       (clk),
        .reset_i     (reset),
        .fifo_data_i (fdata0),
        .fifo_empty_i(fempty0),
        .fifo_rd_o   (rd0),
        .cts_n_i     (cts_n),
        .tx_o        (tx0),
        .busy_o      (busy0),
        .frame_done_o(done0)
    );

    uart_tx_drain #(
        .CLK_DIV  (3),
        .DATA_BITS(8),
        .STOP_BITS(2)
    ) u_dut1 (
        .clk_i       (clk),
        .reset_i     (reset),
        .fifo_data_i (fdata1),
        .fifo_empty_i(fempty1),
        .fifo_rd_o   (rd1),
        .cts_n_i     (cts1_n),
        .tx_o        (tx1),
        .busy_o      (busy1),
        .frame_done_o(done1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[push0[3:0]] = b;
        push0++;
    endtask

    // Waits for the read strobe, then checks its width and the start edge.
    task automatic start_frame(input string tag);
        int n = 0;
        while (rd0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rd seen"}, 32'(rd0), 32'd1);
        @(negedge clk);
        check({tag, " rd one cycle"}, 32'(rd0), 32'd0);
        @(negedge clk);
        check({tag, " start low"}, 32'(tx0), 32'd0);
    endtask

    // Entered on cycle 1 of START; exp[i] is the level of frame bit i.
    task automatic rx_frame(input string tag, input logic [9:0] exp,
                            input int cts_at, input int last_c);
        int done_n = 0;
        int done_at = 0;
        for (int c = 1; c <= last_c; c++) begin
            if (c == cts_at) cts_n = 1'b1;
            if ((c - 1) % 4 == 1) begin
                check($sformatf("%s bit%0d", tag, (c - 1) / 4),
                      32'(tx0), 32'(exp[(c - 1) / 4]));
            end
            if (done0) begin
                done_n++;
                done_at = c;
            end
            if (c < last_c) @(negedge clk);
        end
        if (last_c == 40) begin
            check({tag, " done count"}, done_n, 1);
            check({tag, " done cycle"}, done_at, 40);
        end
    endtask

    initial begin
        int gap;
        int bad;
        int n;
        int r0;
        int len;
        int hi;
        logic [10:0] bits1;

        reset  = 1'b1;
        cts_n  = 1'b0;
        cts1_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx0), 32'd1);
        check("rst rd", 32'(rd0), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst tx1", 32'(tx1), 32'd1);
        reset = 1'b0;

        // Single byte 0xA5
        push(8'hA5);
        start_frame("a5");
        rx_frame("a5", 10'b1101001010, 0, 40);
        @(negedge clk);
        check("a5 busy drop", 32'(busy0), 32'd0);

        // Back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        r0 = rdp0;
        start_frame("b00");
        rx_frame("b00", 10'b1000000000, 0, 40);
        gap = 0;
        @(negedge clk);
        while (tx0 === 1'b1 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("b2b gap", gap, 3);
        rx_frame("bff", 10'b1111111110, 0, 40);
        @(negedge clk);
        check("b2b rd pulses", rdp0 - r0, 2);
        check("b2b fifo empty", 32'(fempty0), 32'd1);

        // CTS holds off a waiting byte
        cts_n = 1'b1;
        push(8'h5A);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd0 || !tx0) bad++;
        end
        check("cts hold", bad, 0);
        cts_n = 1'b0;
        n = 0;
        while (tx0 === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cts start latency", n, 3);
        rx_frame("5a", 10'b1010110100, 0, 40);

        // CTS raised during data bit 3 of 0x3C
        @(negedge clk);
        push(8'h3C);
        push(8'h11);
        start_frame("3c");
        rx_frame("3c", 10'b1001111000, 18, 40);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd0 || !tx0) bad++;
        end
        check("cts mid hold", bad, 0);
        cts_n = 1'b0;
        start_frame("11");
        rx_frame("11", 10'b1000100010, 0, 40);

        // Reset pulse during data bit 5 of 0x0F
        @(negedge clk);
        push(8'h0F);
        push(8'h81);
        start_frame("0f");
        rx_frame("0f", 10'b1000011110, 0, 26);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst tx", 32'(tx0), 32'd1);
        check("mid rst busy", 32'(busy0), 32'd0);
        check("mid rst rd", 32'(rd0), 32'd0);
        reset = 1'b0;
        start_frame("81");
        rx_frame("81", 10'b1100000010, 0, 40);
        @(negedge clk);
        check("81 fifo empty", 32'(fempty0), 32'd1);

        // Two stop bits, CLK_DIV=3, byte 0x55
        push1 = 1;
        n = 0;
        while (tx1 === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s2 start low", 32'(tx1), 32'd0);
        len = 0;
        hi = 0;
        bits1 = '0;
        for (int c = 1; c <= 60 && len == 0; c++) begin
            if ((c - 1) % 3 == 1 && c <= 33) bits1[(c - 1) / 3] = tx1;
            if (c > 27 && c <= 33 && tx1) hi++;
            if (done1) len = c;
            else @(negedge clk);
        end
        check("s2 frame len", len, 33);
        check("s2 stop high", hi, 6);
        check("s2 bits", 32'(bits1), 32'(11'b11010101010));
        @(negedge clk);
        check("s2 busy drop", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART transmitter that drains bytes from the preceding flexible FIFO stage, acting as that FIFO's read-side consumer.
- Pops one byte whenever the FIFO is non-empty and the peer permits (CTS). Serialises it as start bit, DATA_BITS data bits LSB-first, then STOP_BITS stop bits.
- Sits between the host-side TX FIFO and the board serial pin. Read clock of the FIFO is tied to clk_i.

Parameters:
- CLK_DIV, 139, clk_i cycles per bit period (≥2); counter width $clog2(CLK_DIV).
- DATA_BITS, 8, data bits per frame (5..8); fifo_data_i width.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk_i  input  1  system clock; also the FIFO read clock.
- reset_i  input  1  synchronous reset, active-high.
- fifo_data_i  input  DATA_BITS  FIFO output register; valid from the clock after the edge that sampled fifo_rd_o high.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_o  output  1  FIFO read strobe, one clk_i cycle per byte.
- cts_n_i  input  1  clear-to-send, active-low; 1 = hold off new frames.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  high whenever state != IDLE.
- frame_done_o  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- All outputs are registered. Reset values: tx_o=1, fifo_rd_o=0, busy_o=0, frame_done_o=0, state=IDLE, bit and baud counters 0.
- States and transitions:
  - IDLE: if !fifo_empty_i && !cts_n_i, go to POP; else stay.
  - POP: fifo_rd_o=1 for exactly this cycle; go to LOAD.
  - LOAD: fifo_rd_o=0; at the end of the cycle, capture fifo_data_i into the shift register; go to START.
  - START: tx_o=0 for CLK_DIV cycles; go to DATA.
  - DATA: tx_o=shift[0] for CLK_DIV cycles per bit; shift right after each bit; after DATA_BITS bits, go to STOP.
  - STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles; frame_done_o on the final cycle; go to IDLE.
- Latency: if IDLE samples the start condition at edge k, fifo_rd_o is high in cycle k+1 and tx_o goes low in cycle k+3.
- Minimum inter-frame idle time is 3 cycles (IDLE, POP, LOAD) at tx_o=1.
- Baud counter: counts 0..CLK_DIV-1 and reloads to 0 on every bit boundary. No drift across a frame; total frame length is exactly (1+DATA_BITS+STOP_BITS)*CLK_DIV cycles from START entry.
- cts_n_i is sampled only in IDLE. Deasserting CTS mid-frame does not truncate the frame; the next frame is held off.
- fifo_empty_i is sampled only in IDLE. The pop never occurs while empty, so there is no underflow.
- Reset mid-frame: on the next edge, tx_o=1 and state=IDLE. The popped byte is discarded, with no retransmit.
- Reset asserted during POP: fifo_rd_o is driven 0 from the next edge.
- A simultaneous CTS release and FIFO becoming non-empty in the same cycle starts normally.

Test Plan:
- Reset with CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO holding 0xA5 and cts_n_i=0:
  - fifo_rd_o pulses for 1 cycle, 2 cycles later tx_o falls.
  - Bits observed per 4-cycle period: 0,1,0,1,0,0,1,0,1,1.
  - frame_done_o pulses at cycle 40 of the frame; busy_o then drops.
- Back-to-back with FIFO holding 0x00 then 0xFF:
  - Exactly 3 idle-high cycles between the first stop bit end and the second start bit.
  - Exactly 2 fifo_rd_o pulses; FIFO ends empty.
- CTS gating: cts_n_i=1 with FIFO non-empty for 50 cycles gives no fifo_rd_o and tx_o=1. Setting cts_n_i=0 starts the frame within 3 cycles.
- CTS deasserted mid-data bit 3 of 0x3C: the frame completes unchanged, and no new pop occurs while cts_n_i=1.
- reset_i pulsed 1 cycle during data bit 5:
  - tx_o=1, busy_o=0 on the next edge.
  - The following FIFO byte (0x81) is transmitted intact afterwards.
- STOP_BITS=2, CLK_DIV=3, byte 0x55: frame is 33 cycles, with the stop level held high for 6 cycles.
